// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, FSM state types, byte-strobe merge.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle (AW, W, B, AR, R channels) with master and slave views.
interface axi_lite_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_W-1:0]     aw_addr;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_strb;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_W-1:0]     ar_addr;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_W-1:0]     r_data;
    logic [1:0]            r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

endinterface

// File: rtl/axi_lite_reg_bank.sv
// Register storage with one byte-strobed write port and one asynchronous read port.
module axi_lite_reg_bank
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             wr_en_i,
    input  logic [IDX_W-1:0]                 wr_idx_i,
    input  logic [DATA_W-1:0]                wr_data_i,
    input  logic [DATA_W/8-1:0]              wr_strb_i,
    input  logic [IDX_W-1:0]                 rd_idx_i,
    output logic [DATA_W-1:0]                rd_data_o,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wr_en_i) begin
            regs_d[wr_idx_i] = strb_merge(regs_q[wr_idx_i], wr_data_i, wr_strb_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read sees pre-edge contents, so a same-edge read/write returns the old value.
    assign rd_data_o = regs_q[rd_idx_i];
    assign regs_o    = regs_q;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite register-file responder with independent write and read FSMs.
// Define AXI_LITE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    axi_lite_if.slave                       s,
    output logic [NUM_REGS-1:0][DATA_W-1:0] regs_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

`ifdef AXI_LITE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    // Holds all readies low until the first edge after reset release.
    logic ready_en_q;

    wr_state_e             wr_state_q, wr_state_d;
    logic [ADDR_W-1:0]     aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]     w_data_q, w_data_d;
    logic [DATA_W/8-1:0]   w_strb_q, w_strb_d;
    logic [1:0]            b_resp_q, b_resp_d;

    rd_state_e             rd_state_q, rd_state_d;
    logic [DATA_W-1:0]     r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_commit, wr_in_range, rd_in_range;
    logic [ADDR_W-1:0]     wr_addr, rd_addr;
    logic [DATA_W-1:0]     wr_data, rd_data;
    logic [DATA_W/8-1:0]   wr_strb;
    logic                  unused_addr_bits;

    assign aw_hs = s.aw_valid && s.aw_ready;
    assign w_hs  = s.w_valid  && s.w_ready;
    assign ar_hs = s.ar_valid && s.ar_ready;

    // Bypass the holding registers for whichever half arrives on the committing edge.
    assign wr_addr = aw_hs ? s.aw_addr : aw_addr_q;
    assign wr_data = w_hs  ? s.w_data  : w_data_q;
    assign wr_strb = w_hs  ? s.w_strb  : w_strb_q;

    // Commit once both halves are present: either held from earlier or handshaking now.
    assign wr_commit = (aw_hs || wr_state_q == WR_HAVE_AW) && (w_hs || wr_state_q == WR_HAVE_W);

    assign rd_addr     = s.ar_addr;
    assign wr_in_range = (wr_addr[ADDR_W-1:2+IDX_W] == '0);
    assign rd_in_range = (rd_addr[ADDR_W-1:2+IDX_W] == '0);
    assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

    axi_lite_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk_i     (aclk),
        .rst_n_i   (aresetn),
        .wr_en_i   (wr_commit && wr_in_range),
        .wr_idx_i  (wr_addr[2 +: IDX_W]),
        .wr_data_i (wr_data),
        .wr_strb_i (wr_strb),
        .rd_idx_i  (rd_addr[2 +: IDX_W]),
        .rd_data_o (rd_data),
        .regs_o    (regs_o)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
            wr_state_q <= WR_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_resp_q   <= RESP_OKAY;
            rd_state_q <= RD_IDLE;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            ready_en_q <= 1'b1;
            wr_state_q <= wr_state_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_resp_q   <= b_resp_d;
            rd_state_q <= rd_state_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_commit)  wr_state_d = WR_RESP;
                else if (aw_hs) wr_state_d = WR_HAVE_AW;
                else if (w_hs)  wr_state_d = WR_HAVE_W;
            end
            WR_HAVE_AW, WR_HAVE_W: begin
                if (wr_commit) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s.b_ready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_resp_d  = b_resp_q;
        if (aw_hs) aw_addr_d = s.aw_addr;
        if (w_hs) begin
            w_data_d = s.w_data;
            w_strb_d = s.w_strb;
        end
        if (wr_commit) b_resp_d = wr_in_range ? RESP_OKAY : OOR_RESP;
    end

    always_comb begin
        s.aw_ready = 1'b0;
        s.w_ready  = 1'b0;
        s.b_valid  = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                s.aw_ready = ready_en_q;
                s.w_ready  = ready_en_q;
            end
            WR_HAVE_AW: s.w_ready  = ready_en_q;
            WR_HAVE_W:  s.aw_ready = ready_en_q;
            WR_RESP:    s.b_valid  = 1'b1;
            default: ;
        endcase
    end

    assign s.b_resp = b_resp_q;

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs)     rd_state_d = RD_RESP;
            RD_RESP: if (s.r_ready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        if (ar_hs) begin
            r_data_d = rd_in_range ? rd_data : '0;
            r_resp_d = rd_in_range ? RESP_OKAY : OOR_RESP;
        end
    end

    always_comb begin
        s.ar_ready = 1'b0;
        s.r_valid  = 1'b0;
        case (rd_state_q)
            RD_IDLE: s.ar_ready = ready_en_q;
            RD_RESP: s.r_valid  = 1'b1;
            default: ;
        endcase
    end

    assign s.r_data = r_data_q;
    assign s.r_resp = r_resp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: a word-array reference model predicts
// every B/R response; a negedge monitor pops and compares on each handshake.
module tb_axi_lite_slave_regs;

    localparam int unsigned NREGS = 16;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI_LITE_SLVERR_EN
    localparam logic [1:0] OOR = SLVERR;
`else
    localparam logic [1:0] OOR = OKAY;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic [NREGS-1:0][31:0] regs;

    axi_lite_slave_regs #(
        .NUM_REGS (NREGS),
        .DATA_W   (32),
        .ADDR_W   (32)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s       (bus),
        .regs_o  (regs)
    );

    int tests = 0;
    int fails = 0;
    int b_issued = 0;
    int b_seen = 0;
    logic [31:0] model [NREGS];
    logic [1:0]  bq [$];
    rexp_t       rq [$];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Reference model: word array, address in range when below NREGS*4.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] st);
        if (a < NREGS * 4) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
            end
            return OKAY;
        end
        return OOR;
    endfunction

    function automatic rexp_t model_read(input logic [31:0] a);
        rexp_t e;
        if (a < NREGS * 4) begin
            e.data = model[a[5:2]];
            e.resp = OKAY;
        end else begin
            e.data = '0;
            e.resp = OOR;
        end
        return e;
    endfunction

    always @(negedge aclk) begin
        logic [1:0] eb;
        rexp_t er;
        if (aresetn && bus.b_valid && bus.b_ready) begin
            b_seen++;
            if (bq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: got resp %b with no write outstanding", bus.b_resp);
            end else begin
                eb = bq.pop_front();
                chk32("b_resp", 32'(bus.b_resp), 32'(eb));
            end
        end
        if (aresetn && bus.r_valid && bus.r_ready) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL r_unexpected: got data %h with no read outstanding", bus.r_data);
            end else begin
                er = rq.pop_front();
                chk32("r_data", bus.r_data, er.data);
                chk32("r_resp", 32'(bus.r_resp), 32'(er.resp));
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic hs_aw();
        int n = 0;
        bus.aw_valid = 1'b1;
        while (!bus.aw_ready && n < 20) begin tick(); n++; end
        if (n >= 20) timeout_fail("aw_ready");
        tick();
        bus.aw_valid = 1'b0;
    endtask

    task automatic hs_w();
        int n = 0;
        bus.w_valid = 1'b1;
        while (!bus.w_ready && n < 20) begin tick(); n++; end
        if (n >= 20) timeout_fail("w_ready");
        tick();
        bus.w_valid = 1'b0;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap cycles between halves.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            input int order, input int gap, input int bdelay);
        logic [1:0] exp;
        int n = 0;
        bus.aw_addr = a;
        bus.w_data  = d;
        bus.w_strb  = st;
        exp = model_write(a, d, st);
        bq.push_back(exp);
        b_issued++;
        if (order == 0) begin
            bus.aw_valid = 1'b1;
            bus.w_valid  = 1'b1;
            while (!(bus.aw_ready && bus.w_ready) && n < 20) begin tick(); n++; end
            if (n >= 20) timeout_fail("aw_w_ready");
            tick();
            bus.aw_valid = 1'b0;
            bus.w_valid  = 1'b0;
        end else if (order == 1) begin
            hs_aw();
            for (int i = 0; i < gap; i++) tick();
            hs_w();
        end else begin
            hs_w();
            for (int i = 0; i < gap; i++) tick();
            hs_aw();
        end
        chk1("b_valid_latency", bus.b_valid, 1'b1);
        for (int i = 0; i < bdelay; i++) begin
            tick();
            chk1("b_valid_hold", bus.b_valid, 1'b1);
            chk32("b_resp_hold", 32'(bus.b_resp), 32'(exp));
            chk1("aw_ready_in_resp", bus.aw_ready, 1'b0);
            chk1("w_ready_in_resp", bus.w_ready, 1'b0);
        end
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int rdelay);
        int n = 0;
        rq.push_back(model_read(a));
        bus.ar_addr  = a;
        bus.ar_valid = 1'b1;
        while (!bus.ar_ready && n < 20) begin tick(); n++; end
        if (n >= 20) timeout_fail("ar_ready");
        tick();
        bus.ar_valid = 1'b0;
        chk1("r_valid_latency", bus.r_valid, 1'b1);
        for (int i = 0; i < rdelay; i++) begin
            tick();
            chk1("r_valid_hold", bus.r_valid, 1'b1);
            chk1("ar_ready_in_resp", bus.ar_ready, 1'b0);
        end
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NREGS; i++) chk32($sformatf("regs_o[%0d]", i), regs[i], model[i]);
    endtask

    task automatic check_reset_outputs();
        chk1("rst_b_valid", bus.b_valid, 1'b0);
        chk1("rst_r_valid", bus.r_valid, 1'b0);
        chk1("rst_aw_ready", bus.aw_ready, 1'b0);
        chk1("rst_w_ready", bus.w_ready, 1'b0);
        chk1("rst_ar_ready", bus.ar_ready, 1'b0);
        chk32("rst_b_resp", 32'(bus.b_resp), 32'(OKAY));
        chk32("rst_r_resp", 32'(bus.r_resp), 32'(OKAY));
        chk32("rst_r_data", bus.r_data, 32'h0);
        for (int i = 0; i < NREGS; i++) chk32($sformatf("rst_regs[%0d]", i), regs[i], 32'h0);
    endtask

    task automatic release_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk1("pre_edge_aw_ready", bus.aw_ready, 1'b0);
        tick();
        chk1("post_rst_aw_ready", bus.aw_ready, 1'b1);
        chk1("post_rst_w_ready", bus.w_ready, 1'b1);
        chk1("post_rst_ar_ready", bus.ar_ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rexp_t er;
        logic [1:0] eb;
        bus.aw_valid = 1'b0; bus.aw_addr = '0;
        bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0;
        bus.b_ready  = 1'b0;
        bus.ar_valid = 1'b0; bus.ar_addr = '0;
        bus.r_ready  = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        #22;
        check_reset_outputs();
        release_reset();

        // AW+W together, then read back
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk32("reg2_deadbeef", regs[2], 32'hDEADBEEF);
        do_read(32'h08, 0);

        // W first, AW three edges later, partial strobes onto all-ones
        do_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        b0 = b_seen;
        do_write(32'h04, 32'h12345678, 4'b0101, 2, 2, 0);
        chk32("reg1_merge", regs[1], 32'hFF34FF78);
        chk32("one_b_response", 32'(b_seen - b0), 32'd1);

        // Stalled B channel
        do_write(32'h0C, 32'hA5A5_0001, 4'hF, 1, 1, 5);

        // Out-of-range read and write, zero-strobe write
        do_read(32'h40, 2);
        do_write(32'h44, 32'h1111_2222, 4'hF, 0, 0, 1);
        do_write(32'h0B, 32'h0, 4'h0, 0, 0, 0);
        do_read(32'h08, 0);
        check_regs();

        // Read captured on the same edge as a write commit to that register
        er = model_read(32'h08);
        rq.push_back(er);
        eb = model_write(32'h08, 32'hCAFEF00D, 4'hF);
        bq.push_back(eb);
        b_issued++;
        bus.aw_addr = 32'h08; bus.w_data = 32'hCAFEF00D; bus.w_strb = 4'hF; bus.ar_addr = 32'h08;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
        chk1("same_edge_b_valid", bus.b_valid, 1'b1);
        chk1("same_edge_r_valid", bus.r_valid, 1'b1);
        bus.b_ready = 1'b1; bus.r_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0; bus.r_ready = 1'b0;
        chk32("reg2_new", regs[2], 32'hCAFEF00D);

        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                do_read(a, int'($urandom_range(0, 3)));
            end
        end
        check_regs();

        // Reset with both channels holding a response
        bus.aw_addr = 32'h04; bus.w_data = 32'h5555AAAA; bus.w_strb = 4'hF; bus.ar_addr = 32'h08;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
        chk1("pre_rst_b_valid", bus.b_valid, 1'b1);
        chk1("pre_rst_r_valid", bus.r_valid, 1'b1);
        tick();
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        tick();
        release_reset();

        do_write(32'h3C, 32'h0BAD_F00D, 4'b1100, 1, 0, 0);
        do_read(32'h3C, 1);
        check_regs();

        repeat (3) tick();
        chk32("b_queue_drained", 32'(bq.size()), 32'd0);
        chk32("r_queue_drained", 32'(rq.size()), 32'd0);
        chk32("b_count", 32'(b_seen), 32'(b_issued));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
